// File: rtl/mem_access_unit_pkg.sv
// Purpose: opcode, access-size and FSM-state constants shared by the load/store unit.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
package mem_access_unit_pkg;

  // MIPS load/store primary opcodes
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;

  // data_size encodings on the bus
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_RESP  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Non-memory opcodes report word size; callers gate on is_load/is_store.
  function automatic logic [1:0] op_size(input logic [5:0] op);
    if ((op == OP_LB) || (op == OP_LBU) || (op == OP_SB)) return SIZE_BYTE;
    if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) return SIZE_HALF;
    return SIZE_WORD;
  endfunction

endpackage

// File: rtl/mem_data_align.sv
// Purpose: byte-lane steering for stores, load extraction/extension, alignment check.
// Latency: combinational.
// Backpressure: none (no handshake).
// Ports: op/addr_lo/wdata/rdata in; wstrb, bus_wdata, ext_rdata, adel, ades out.
module mem_data_align
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int LANES = DATA_W / 8,
  localparam int LB_W  = $clog2(LANES)
) (
  input  logic [5:0]        op,
  input  logic [LB_W-1:0]   addr_lo,
  input  logic [31:0]       wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [LANES-1:0]  wstrb,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [31:0]       ext_rdata,
  output logic              adel,
  output logic              ades
);

  logic [1:0]        size;
  logic              misaligned;
  logic [LANES-1:0]  base_strb;
  logic [DATA_W-1:0] shifted;

  always_comb begin
    size       = op_size(op);
    misaligned = ((size == SIZE_WORD) && (addr_lo[1:0] != 2'b00)) ||
                 ((size == SIZE_HALF) && addr_lo[0]);
    adel       = is_load(op) && misaligned;
    ades       = is_store(op) && misaligned;

    base_strb = '0;
    bus_wdata = '0;
    case (size)
      SIZE_BYTE: begin
        base_strb = LANES'(1);
        bus_wdata = {LANES{wdata[7:0]}};
      end
      SIZE_HALF: begin
        base_strb = LANES'(2'b11);
        bus_wdata = {(LANES/2){wdata[15:0]}};
      end
      default: begin
        base_strb = LANES'(4'hf);
        bus_wdata = {(LANES/4){wdata}};
      end
    endcase
    wstrb = is_store(op) ? (base_strb << addr_lo) : '0;

    // Shifting by the full byte offset selects the 32-bit lane and the
    // byte/half within it in one step; aligned accesses keep it in range.
    shifted = rdata >> {addr_lo, 3'b000};
    case (op)
      OP_LB:   ext_rdata = {{24{shifted[7]}}, shifted[7:0]};
      OP_LBU:  ext_rdata = {24'd0, shifted[7:0]};
      OP_LH:   ext_rdata = {{16{shifted[15]}}, shifted[15:0]};
      OP_LHU:  ext_rdata = {16'd0, shifted[15:0]};
      OP_LW:   ext_rdata = shifted[31:0];
      default: ext_rdata = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Purpose: single-outstanding MIPS load/store unit onto a req/addr_ok/data_ok SRAM bus.
// Latency: 2 cycles accept->rsp_valid with zero-wait bus; 1 cycle for address errors.
// Backpressure: req_ready only in IDLE; bus outputs held until addr_ok.
// Ports: clk/resetn, flush, req_* (from EX), rsp_* (to MEM/WB), data_* (bus).
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [5:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [31:0]         req_wdata,
  output logic                rsp_valid,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_adel,
  output logic                rsp_ades,
  output logic [ADDR_W-1:0]   rsp_badvaddr,
  output logic                data_req,
  output logic                data_wr,
  output logic [1:0]          data_size,
  output logic [ADDR_W-1:0]   data_addr,
  output logic [DATA_W/8-1:0] data_wstrb,
  output logic [DATA_W-1:0]   data_wdata,
  input  logic                data_addr_ok,
  input  logic                data_data_ok,
  input  logic [DATA_W-1:0]   data_rdata
);

  localparam int LANES = DATA_W / 8;
  localparam int LB_W  = $clog2(LANES);

  logic [2:0]        state;
  logic [5:0]        op_q;
  logic [LB_W-1:0]   addr_lo_q;

  logic [5:0]        al_op;
  logic [LB_W-1:0]   al_addr;
  logic [LANES-1:0]  al_wstrb;
  logic [DATA_W-1:0] al_wdata;
  logic [31:0]       al_rdata;
  logic              al_adel;
  logic              al_ades;
  logic              accept;
  logic              go_bus;

  // One aligner serves both directions: in IDLE it looks at the incoming
  // request (checks + store lanes), afterwards at the latched op for loads.
  assign al_op   = (state == ST_IDLE) ? req_op : op_q;
  assign al_addr = (state == ST_IDLE) ? req_addr[LB_W-1:0] : addr_lo_q;

  mem_data_align #(.DATA_W(DATA_W)) u_align (
    .op        (al_op),
    .addr_lo   (al_addr),
    .wdata     (req_wdata),
    .rdata     (data_rdata),
    .wstrb     (al_wstrb),
    .bus_wdata (al_wdata),
    .ext_rdata (al_rdata),
    .adel      (al_adel),
    .ades      (al_ades)
  );

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_ready && req_valid && !flush;
  assign go_bus    = (is_load(req_op) || is_store(req_op)) && !(al_adel || al_ades);
  assign rsp_valid = (state == ST_RESP) && !flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      op_q         <= '0;
      addr_lo_q    <= '0;
      rsp_rdata    <= '0;
      rsp_adel     <= 1'b0;
      rsp_ades     <= 1'b0;
      rsp_badvaddr <= '0;
      data_req     <= 1'b0;
      data_wr      <= 1'b0;
      data_size    <= SIZE_BYTE;
      data_addr    <= '0;
      data_wstrb   <= '0;
      data_wdata   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q         <= req_op;
            addr_lo_q    <= req_addr[LB_W-1:0];
            rsp_rdata    <= '0;
            rsp_adel     <= al_adel;
            rsp_ades     <= al_ades;
            rsp_badvaddr <= (al_adel || al_ades) ? req_addr : '0;
            if (go_bus) begin
              state      <= ST_REQ;
              data_req   <= 1'b1;
              data_wr    <= is_store(req_op);
              data_size  <= op_size(req_op);
              data_addr  <= req_addr & ~ADDR_W'(LANES - 1);
              data_wstrb <= al_wstrb;
              data_wdata <= al_wdata;
            end else begin
              state <= ST_RESP;
            end
          end
        end
        ST_REQ: begin
          if (data_addr_ok) begin
            data_req   <= 1'b0;
            data_wstrb <= '0;
            if (data_data_ok) begin
              rsp_rdata <= al_rdata;
              state     <= flush ? ST_IDLE : ST_RESP;
            end else begin
              // address already taken by the bus: a flush must still drain it
              state <= flush ? ST_DRAIN : ST_WAIT;
            end
          end else if (flush) begin
            data_req   <= 1'b0;
            data_wstrb <= '0;
            state      <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (data_data_ok) begin
            rsp_rdata <= al_rdata;
            state     <= flush ? ST_IDLE : ST_RESP;
          end else if (flush) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (data_data_ok) state <= ST_IDLE;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Purpose: self-checking bench for mem_access_unit (32-bit and 64-bit data bus instances).
// Latency: n/a.
// Backpressure: bus addr_ok/data_ok delays are driven by the bench.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  int          checks = 0;
  int          failures = 0;

  // 32-bit instance signals
  logic        flush = 1'b0, req_valid = 1'b0, req_ready;
  logic [5:0]  req_op = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, rsp_adel, rsp_ades;
  logic [31:0] rsp_rdata, rsp_badvaddr;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;
  logic [31:0] data_rdata = '0;

  // 64-bit instance signals
  logic        flush64 = 1'b0, req_valid64 = 1'b0, req_ready64;
  logic [5:0]  req_op64 = '0;
  logic [31:0] req_addr64 = '0, req_wdata64 = '0;
  logic        rsp_valid64, rsp_adel64, rsp_ades64;
  logic [31:0] rsp_rdata64, rsp_badvaddr64;
  logic        data_req64, data_wr64;
  logic [1:0]  data_size64;
  logic [31:0] data_addr64;
  logic [63:0] data_wdata64;
  logic [7:0]  data_wstrb64;
  logic        data_addr_ok64 = 1'b0, data_data_ok64 = 1'b0;
  logic [63:0] data_rdata64 = '0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut32 (
    .clk(clk), .resetn(resetn), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_adel(rsp_adel),
    .rsp_ades(rsp_ades), .rsp_badvaddr(rsp_badvaddr),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  mem_access_unit #(.ADDR_W(32), .DATA_W(64)) dut64 (
    .clk(clk), .resetn(resetn), .flush(flush64),
    .req_valid(req_valid64), .req_ready(req_ready64), .req_op(req_op64),
    .req_addr(req_addr64), .req_wdata(req_wdata64),
    .rsp_valid(rsp_valid64), .rsp_rdata(rsp_rdata64), .rsp_adel(rsp_adel64),
    .rsp_ades(rsp_ades64), .rsp_badvaddr(rsp_badvaddr64),
    .data_req(data_req64), .data_wr(data_wr64), .data_size(data_size64),
    .data_addr(data_addr64), .data_wstrb(data_wstrb64), .data_wdata(data_wdata64),
    .data_addr_ok(data_addr_ok64), .data_data_ok(data_data_ok64), .data_rdata(data_rdata64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One request on the 32-bit unit, bus answering after aok_dly cycles of
  // data_req and data_ok dok_dly cycles after addr_ok; checked against a
  // byte-level reference model of the MIPS load/store rules.
  task automatic do_op(input string tag, input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd,
                       input int aok_dly, input int dok_dly);
    bit ld, st, mis, seen, got, aok_done, outst, aok, ok;
    int sz, off, lat, n, aok_cnt, dok_left;
    logic [63:0] v;
    logic [31:0] exp_rd, exp_wd, exp_badv, o_rd, o_badv, s_addr, s_wd;
    logic [3:0]  exp_strb, s_strb;
    logic [1:0]  s_size;
    logic        o_adel, o_ades, s_wr;
    ld  = (op == 6'h20) || (op == 6'h21) || (op == 6'h23) || (op == 6'h24) || (op == 6'h25);
    st  = (op == 6'h28) || (op == 6'h29) || (op == 6'h2b);
    if (op == 6'h20 || op == 6'h24 || op == 6'h28) sz = 1;
    else if (op == 6'h21 || op == 6'h25 || op == 6'h29) sz = 2;
    else sz = 4;
    off = int'(addr % 4);
    mis = (ld || st) && (addr % sz != 0);
    v = (64'(rd) >> (8 * off)) & ((64'd1 << (8 * sz)) - 1);
    if ((op == 6'h20 || op == 6'h21) && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
    exp_rd   = (ld && !mis) ? v[31:0] : 32'd0;
    exp_badv = mis ? addr : 32'd0;
    exp_strb = '0;
    exp_wd   = '0;
    for (int k = 0; k < 4; k++) begin
      if (st && k >= off && k < off + sz) exp_strb[k] = 1'b1;
      exp_wd[8*k +: 8] = wd[8*(k % sz) +: 8];
    end

    @(negedge clk);
    chk({tag, ".ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    n = 0; got = 0; seen = 0; aok_done = 0; outst = 0; aok_cnt = 0; dok_left = 0; lat = 0;
    o_rd = '0; o_adel = 0; o_ades = 0; o_badv = '0;
    s_addr = '0; s_wd = '0; s_strb = '0; s_size = '0; s_wr = 0;
    while (n < 40 && !got) begin
      @(negedge clk);
      n++;
      req_valid = 1'b0;
      if (rsp_valid) begin
        got = 1; lat = n; o_rd = rsp_rdata; o_adel = rsp_adel; o_ades = rsp_ades; o_badv = rsp_badvaddr;
      end
      aok = 0; ok = 0;
      if (outst) begin
        if (dok_left == 0) begin ok = 1; outst = 0; end
        else dok_left--;
      end
      if (data_req && !aok_done) begin
        if (!seen) begin
          seen = 1; s_addr = data_addr; s_wd = data_wdata; s_strb = data_wstrb;
          s_size = data_size; s_wr = data_wr;
        end
        if (aok_cnt == aok_dly) begin
          aok = 1; aok_done = 1;
          if (dok_dly == 0) ok = 1;
          else begin outst = 1; dok_left = dok_dly - 1; end
        end else aok_cnt++;
      end
      data_addr_ok = aok;
      data_data_ok = ok;
      data_rdata   = ok ? rd : $urandom;
    end
    chk({tag, ".rsp_seen"}, 64'(got), 64'd1);
    chk({tag, ".latency"}, 64'(lat), (ld || st) && !mis ? 64'(2 + aok_dly + dok_dly) : 64'd1);
    chk({tag, ".rdata"}, 64'(o_rd), 64'(exp_rd));
    chk({tag, ".adel"}, 64'(o_adel), 64'(ld && mis));
    chk({tag, ".ades"}, 64'(o_ades), 64'(st && mis));
    chk({tag, ".badvaddr"}, 64'(o_badv), 64'(exp_badv));
    chk({tag, ".bus_used"}, 64'(seen), 64'((ld || st) && !mis));
    if (seen) begin
      chk({tag, ".addr"}, 64'(s_addr), 64'(addr - 32'(off)));
      chk({tag, ".wr"}, 64'(s_wr), 64'(st));
      chk({tag, ".size"}, 64'(s_size), (sz == 1) ? 64'd0 : (sz == 2) ? 64'd1 : 64'd2);
      chk({tag, ".wstrb"}, 64'(s_strb), 64'(exp_strb));
      if (st) chk({tag, ".wdata"}, 64'(s_wd), 64'(exp_wd));
    end
    @(negedge clk);
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    chk({tag, ".pulse_end"}, 64'(rsp_valid), 64'd0);
    chk({tag, ".ready_back"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    logic [5:0] ops [9];
    int rv;
    ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2b, 6'h0f};

    // reset values
    #3;
    chk("rst.req_ready", 64'(req_ready), 64'd1);
    chk("rst.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst.rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst.rsp_flags", {62'd0, rsp_adel, rsp_ades}, 64'd0);
    chk("rst.badvaddr", 64'(rsp_badvaddr), 64'd0);
    chk("rst.data_req", 64'(data_req), 64'd0);
    chk("rst.wstrb", 64'(data_wstrb), 64'd0);
    chk("rst.wstrb64", 64'(data_wstrb64), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // directed cases
    do_op("lw_fast", 6'h23, 32'h1000, 32'h0, 32'hdeadbeef, 0, 0);
    do_op("lb_sign", 6'h20, 32'h1003, 32'h0, 32'h80123456, 0, 0);
    do_op("lbu_zero", 6'h24, 32'h1003, 32'h0, 32'h80123456, 0, 0);
    do_op("sh_2002", 6'h29, 32'h2002, 32'h0000abcd, 32'h0, 0, 0);
    do_op("lw_misal", 6'h23, 32'h1002, 32'h0, 32'h12345678, 0, 0);
    do_op("sw_misal", 6'h2b, 32'h1001, 32'h11223344, 32'h0, 0, 0);
    do_op("lh_misal", 6'h21, 32'h1005, 32'h0, 32'h0, 0, 0);
    do_op("nonmem", 6'h0f, 32'h1000, 32'h0, 32'h0, 0, 0);
    do_op("lh_slow", 6'h21, 32'h1002, 32'h0, 32'h8001cafe, 2, 3);

    // randomized
    for (int i = 0; i < 40; i++) begin
      do_op($sformatf("rnd%0d", i), ops[$urandom_range(0, 8)], 32'h3000 + $urandom_range(0, 15),
            $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // flush while waiting for data: drained silently
    rv = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = 6'h23; req_addr = 32'h1000;
    @(negedge clk);
    req_valid = 1'b0; rv += int'(rsp_valid);
    chk("fw.data_req", 64'(data_req), 64'd1);
    data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0; rv += int'(rsp_valid);
    chk("fw.data_req_drop", 64'(data_req), 64'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; rv += int'(rsp_valid);
    chk("fw.ready_drain", 64'(req_ready), 64'd0);
    @(negedge clk);
    rv += int'(rsp_valid);
    @(negedge clk);
    rv += int'(rsp_valid);
    chk("fw.ready_before_dok", 64'(req_ready), 64'd0);
    data_data_ok = 1'b1; data_rdata = 32'h55aa55aa;
    @(negedge clk);
    data_data_ok = 1'b0; rv += int'(rsp_valid);
    chk("fw.ready_after_dok", 64'(req_ready), 64'd1);
    @(negedge clk);
    rv += int'(rsp_valid);
    chk("fw.no_rsp", 64'(rv), 64'd0);

    // flush before addr_ok: request dropped
    req_valid = 1'b1; req_op = 6'h2b; req_addr = 32'h2000; req_wdata = 32'h1;
    @(negedge clk);
    req_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fr.data_req", 64'(data_req), 64'd0);
    chk("fr.wstrb", 64'(data_wstrb), 64'd0);
    chk("fr.ready", 64'(req_ready), 64'd1);
    chk("fr.no_rsp", 64'(rsp_valid), 64'd0);

    // flush during the response cycle suppresses the pulse
    @(negedge clk);
    req_valid = 1'b1; req_op = 6'h23; req_addr = 32'h1001;
    @(negedge clk);
    req_valid = 1'b0;
    flush = 1'b1;
    #1;
    chk("fp.rsp_suppressed", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("fp.ready", 64'(req_ready), 64'd1);

    // reset mid-transaction
    req_valid = 1'b1; req_op = 6'h23; req_addr = 32'h1000;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mr.data_req_before", 64'(data_req), 64'd1);
    resetn = 1'b0;
    #1;
    chk("mr.data_req", 64'(data_req), 64'd0);
    chk("mr.ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    resetn = 1'b1;

    // 64-bit bus: SB at byte 5
    @(negedge clk);
    req_valid64 = 1'b1; req_op64 = 6'h28; req_addr64 = 32'h5; req_wdata64 = 32'h77;
    @(negedge clk);
    req_valid64 = 1'b0;
    chk("w64.data_req", 64'(data_req64), 64'd1);
    chk("w64.wstrb", 64'(data_wstrb64), 64'h20);
    chk("w64.addr", 64'(data_addr64), 64'h0);
    chk("w64.wdata", data_wdata64, 64'h7777777777777777);
    chk("w64.size", 64'(data_size64), 64'd0);
    data_addr_ok64 = 1'b1; data_data_ok64 = 1'b1;
    @(negedge clk);
    data_addr_ok64 = 1'b0; data_data_ok64 = 1'b0;
    chk("w64.rsp_valid", 64'(rsp_valid64), 64'd1);
    chk("w64.rsp_rdata", 64'(rsp_rdata64), 64'd0);

    // 64-bit bus: loads from the upper word lane
    @(negedge clk);
    req_valid64 = 1'b1; req_op64 = 6'h23; req_addr64 = 32'hc;
    @(negedge clk);
    req_valid64 = 1'b0;
    chk("r64.addr", 64'(data_addr64), 64'h8);
    chk("r64.wstrb", 64'(data_wstrb64), 64'h0);
    data_addr_ok64 = 1'b1; data_data_ok64 = 1'b1; data_rdata64 = 64'h11223344_55667788;
    @(negedge clk);
    data_addr_ok64 = 1'b0; data_data_ok64 = 1'b0;
    chk("r64.lw", 64'(rsp_rdata64), 64'h11223344);
    @(negedge clk);
    req_valid64 = 1'b1; req_op64 = 6'h20; req_addr64 = 32'h4;
    @(negedge clk);
    req_valid64 = 1'b0;
    data_addr_ok64 = 1'b1; data_data_ok64 = 1'b1; data_rdata64 = 64'h000000f0_00000000;
    @(negedge clk);
    data_addr_ok64 = 1'b0; data_data_ok64 = 1'b0;
    chk("r64.lb_valid", 64'(rsp_valid64), 64'd1);
    chk("r64.lb", 64'(rsp_rdata64), 64'hfffffff0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
